// File: rtl/oledrgb_spi_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : oledrgb_spi_monitor_if
//  Description : Bus bundle between the OLEDrgb SPI capture monitor and the
//                logic that observes it. It carries the raw SPI pair, the
//                clear/readback controls and every capture status output.
//  Ports       : i_sclk, i_mosi   - SPI pair, asynchronous to the system clock
//                i_clear          - one-cycle clear pulse
//                i_rd_addr[3:0]   - buffer read address
//                o_rd_data[7:0]   - registered buffer readback
//                o_byte[7:0]      - last completed byte
//                o_byte_valid     - one-cycle pulse per completed byte
//                o_num_bytes[3:0] - bytes stored in current/last frame
//                o_frame_done     - one-cycle pulse at frame end
//                o_busy           - frame open
//                o_overflow       - sticky, byte lost to a full buffer
//                o_frame_err      - sticky, frame ended mid-byte
//  Revision    : 1.0 - initial release
// ============================================================================
interface oledrgb_spi_monitor_if;
    logic       i_sclk;
    logic       i_mosi;
    logic       i_clear;
    logic [3:0] i_rd_addr;
    logic [7:0] o_rd_data;
    logic [7:0] o_byte;
    logic       o_byte_valid;
    logic [3:0] o_num_bytes;
    logic       o_frame_done;
    logic       o_busy;
    logic       o_overflow;
    logic       o_frame_err;

    // Observer side: drives the SPI pair and controls, reads status.
    modport master (
        output i_sclk, i_mosi, i_clear, i_rd_addr,
        input  o_rd_data, o_byte, o_byte_valid, o_num_bytes,
               o_frame_done, o_busy, o_overflow, o_frame_err
    );

    // Monitor side.
    modport slave (
        input  i_sclk, i_mosi, i_clear, i_rd_addr,
        output o_rd_data, o_byte, o_byte_valid, o_num_bytes,
               o_frame_done, o_busy, o_overflow, o_frame_err
    );
endinterface
`default_nettype wire

// File: rtl/oledrgb_spi_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : oledrgb_spi_monitor
//  Description : Oversampling SPI mode-0 receiver for the OLEDrgb command
//                path. Deserializes MSB-first bytes, groups them into frames
//                delimited by SCLK idle time and stores each frame in a
//                MAX_BYTES-entry buffer readable by address. Listen-only.
//  Ports       : i_clk   - system clock
//                i_reset - synchronous active-high reset
//                bus     - oledrgb_spi_monitor_if.slave (SPI pair, clear,
//                          readback and capture status)
//  Revision    : 1.0 - initial release
// ============================================================================
module oledrgb_spi_monitor #(
    parameter int   MAX_BYTES = 15,
    parameter int   TIMEOUT   = 64,
    parameter logic SCLK_IDLE = 1'b0
) (
    input  wire logic              i_clk,
    input  wire logic              i_reset,
    oledrgb_spi_monitor_if.slave   bus
);

    localparam int         c_TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [3:0] c_MAX     = 4'(MAX_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers. The prev flop sits behind sync2 so that an edge is
    // seen for exactly one cycle. Resetting the SCLK chain to its idle
    // level keeps reset release from looking like an edge.
    // ------------------------------------------------------------------
    logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic mosi_s1_q, mosi_s2_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sclk_s1_q   <= SCLK_IDLE;
            sclk_s2_q   <= SCLK_IDLE;
            sclk_prev_q <= SCLK_IDLE;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
        end else begin
            sclk_s1_q   <= bus.i_sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            mosi_s1_q   <= bus.i_mosi;
            mosi_s2_q   <= mosi_s1_q;
        end
    end

    logic w_rise;
    assign w_rise = sclk_s2_q & ~sclk_prev_q;

    // ------------------------------------------------------------------
    // Frame FSM, deserializer and buffer writes.
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic [2:0]        bit_cnt_q;
    logic [c_TO_W-1:0] to_cnt_q;
    logic [7:0]        byte_q;
    logic              byte_valid_q;
    logic [3:0]        num_bytes_q;
    logic              frame_done_q;
    logic              busy_q;
    logic              overflow_q;
    logic              frame_err_q;
    logic [7:0]        mem_q [MAX_BYTES];
    logic [7:0]        rd_data_q;

    // MOSI is sampled from its own sync2 in the same cycle the edge is seen,
    // so both paths carry identical latency.
    assign shift_d = {shift_q[6:0], mosi_s2_q};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            to_cnt_q     <= '0;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            num_bytes_q  <= 4'd0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            for (int i = 0; i < MAX_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.i_clear) begin
                // Clear wins over any coincident edge; that edge is lost.
                state_q     <= S_IDLE;
                bit_cnt_q   <= 3'd0;
                to_cnt_q    <= '0;
                num_bytes_q <= 4'd0;
                busy_q      <= 1'b0;
                overflow_q  <= 1'b0;
                frame_err_q <= 1'b0;
                for (int i = 0; i < MAX_BYTES; i++) begin
                    mem_q[i] <= 8'h00;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // Count and buffer survive until the next frame's
                        // first edge so software can read the last frame.
                        if (w_rise) begin
                            num_bytes_q <= 4'd0;
                            shift_q     <= {7'd0, mosi_s2_q};
                            bit_cnt_q   <= 3'd1;
                            to_cnt_q    <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= S_RECV;
                        end
                    end
                    S_RECV: begin
                        if (w_rise) begin
                            shift_q  <= shift_d;
                            to_cnt_q <= '0;
                            if (bit_cnt_q == 3'd7) begin
                                byte_q       <= shift_d;
                                byte_valid_q <= 1'b1;
                                bit_cnt_q    <= 3'd0;
                                if (num_bytes_q < c_MAX) begin
                                    mem_q[num_bytes_q] <= shift_d;
                                    num_bytes_q        <= num_bytes_q + 4'd1;
                                end else begin
                                    overflow_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end else if (to_cnt_q == c_TO_LAST) begin
                            if (bit_cnt_q != 3'd0) begin
                                frame_err_q <= 1'b1;
                            end
                            bit_cnt_q    <= 3'd0;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    S_DONE: begin
                        // One-cycle frame_done window; edges here are ignored.
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Readback. Addresses beyond the buffer depth read as zero.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_data_q <= 8'h00;
        end else if (bus.i_rd_addr < c_MAX) begin
            rd_data_q <= mem_q[bus.i_rd_addr];
        end else begin
            rd_data_q <= 8'h00;
        end
    end

    assign bus.o_rd_data    = rd_data_q;
    assign bus.o_byte       = byte_q;
    assign bus.o_byte_valid = byte_valid_q;
    assign bus.o_num_bytes  = num_bytes_q;
    assign bus.o_frame_done = frame_done_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_overflow   = overflow_q;
    assign bus.o_frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_oledrgb_spi_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oledrgb_spi_monitor
//  Description : Scoreboard bench for oledrgb_spi_monitor. Stimulus tasks
//                push expected bytes and frame summaries into queues; a
//                negedge monitor pops and compares whenever the DUT pulses
//                o_byte_valid or o_frame_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oledrgb_spi_monitor;

    localparam int TIMEOUT = 64;
    localparam int DEPTH   = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    initial forever #5 clk = ~clk;

    oledrgb_spi_monitor_if bus();

    oledrgb_spi_monitor #(
        .MAX_BYTES (DEPTH),
        .TIMEOUT   (TIMEOUT),
        .SCLK_IDLE (1'b0)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: what the buffer and flags should hold, derived from
    // the bytes each frame carries.
    // ------------------------------------------------------------------
    typedef struct {
        int num;
        bit ovf;
        bit ferr;
    } frame_t;

    logic [7:0] m_buf [DEPTH];
    int         m_num;
    bit         m_ovf;
    bit         m_ferr;
    logic [7:0] tx_q [$];
    logic [7:0] exp_byte_q [$];
    frame_t     exp_frame_q [$];

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_buf[i] = 8'h00;
        m_num  = 0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic model_frame(input int extra);
        int n;
        n = tx_q.size();
        foreach (tx_q[i]) begin
            exp_byte_q.push_back(tx_q[i]);
            if (i < DEPTH) m_buf[i] = tx_q[i];
        end
        m_num = (n < DEPTH) ? n : DEPTH;
        if (n > DEPTH)  m_ovf  = 1'b1;
        if (extra != 0) m_ferr = 1'b1;
        exp_frame_q.push_back('{m_num, m_ovf, m_ferr});
    endtask

    function automatic logic [7:0] exp_rd(input int a);
        if (a < DEPTH) return m_buf[a];
        return 8'h00;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [7:0] mon_b;
    frame_t     mon_f;

    always @(negedge clk) begin
        if (bus.o_byte_valid === 1'b1) begin
            if (exp_byte_q.size() == 0) begin
                check("unexpected_byte_valid", 32'(bus.o_byte), 32'hFFFF_FFFF);
            end else begin
                mon_b = exp_byte_q.pop_front();
                check("o_byte", 32'(bus.o_byte), 32'(mon_b));
            end
        end
        if (bus.o_frame_done === 1'b1) begin
            if (exp_frame_q.size() == 0) begin
                check("unexpected_frame_done", 32'(bus.o_num_bytes), 32'hFFFF_FFFF);
            end else begin
                mon_f = exp_frame_q.pop_front();
                check("o_num_bytes", 32'(bus.o_num_bytes), 32'(mon_f.num));
                check("o_overflow",  32'(bus.o_overflow),  32'(mon_f.ovf));
                check("o_frame_err", 32'(bus.o_frame_err), 32'(mon_f.ferr));
                check("o_busy_at_done", 32'(bus.o_busy), 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all entered and left on a negedge of clk)
    // ------------------------------------------------------------------
    task automatic sclk_bit(input logic b, input int half);
        bus.i_mosi = b;
        repeat (half) @(negedge clk);
        bus.i_sclk = 1'b1;
        repeat (half) @(negedge clk);
        bus.i_sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int half);
        for (int i = 7; i >= 0; i--) sclk_bit(b[i], half);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < TIMEOUT * 4 && exp_frame_q.size() != 0; i++) @(negedge clk);
        check("frame_done_seen", 32'(exp_frame_q.size()), 32'd0);
        bus.i_mosi = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Sends tx_q plus `extra` leading bits of xval, then idles out the frame.
    task automatic send_frame(input int extra, input logic [7:0] xval, input int half);
        model_frame(extra);
        foreach (tx_q[i]) send_byte(tx_q[i], half);
        for (int i = 0; i < extra; i++) sclk_bit(xval[7 - i], half);
        bus.i_mosi = 1'b0;
        wait_drain();
    endtask

    task automatic readback();
        for (int a = 0; a < 16; a++) begin
            bus.i_rd_addr = 4'(a);
            @(negedge clk);
            check($sformatf("rd_data[%0d]", a), 32'(bus.o_rd_data), 32'(exp_rd(a)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_data"},    32'(bus.o_rd_data),    32'd0);
        check({tag, "_byte"},       32'(bus.o_byte),       32'd0);
        check({tag, "_byte_valid"}, 32'(bus.o_byte_valid), 32'd0);
        check({tag, "_num_bytes"},  32'(bus.o_num_bytes),  32'd0);
        check({tag, "_frame_done"}, 32'(bus.o_frame_done), 32'd0);
        check({tag, "_busy"},       32'(bus.o_busy),       32'd0);
        check({tag, "_overflow"},   32'(bus.o_overflow),   32'd0);
        check({tag, "_frame_err"},  32'(bus.o_frame_err),  32'd0);
    endtask

    task automatic idle_clear();
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
        model_clear();
        @(negedge clk);
        check("clear_num_bytes", 32'(bus.o_num_bytes), 32'd0);
        check("clear_overflow",  32'(bus.o_overflow),  32'd0);
        check("clear_frame_err", 32'(bus.o_frame_err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bus.i_sclk    = 1'b0;
        bus.i_mosi    = 1'b0;
        bus.i_clear   = 1'b0;
        bus.i_rd_addr = 4'd0;
        model_clear();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single byte
        tx_q = '{8'hA5};
        send_frame(0, 8'h00, 3);
        readback();

        // 2: eight bytes, SCLK period 10
        tx_q = '{};
        for (int i = 1; i <= 8; i++) tx_q.push_back(8'(i));
        send_frame(0, 8'h00, 5);
        readback();

        // 3: sixteen bytes overflow the buffer
        tx_q = '{};
        for (int i = 16; i < 32; i++) tx_q.push_back(8'(i));
        send_frame(0, 8'h00, 2);
        readback();

        // 4: one byte plus 5 stray bits
        tx_q = '{8'h3C};
        send_frame(5, 8'hB8, 3);
        readback();

        // 5: reset after 4 bits of a byte
        for (int i = 0; i < 4; i++) sclk_bit(1'b1, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        rst = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        tx_q = '{8'h5A};
        send_frame(0, 8'h00, 3);
        readback();

        // 6: clear coincident with a detected SCLK edge mid-frame
        exp_byte_q.push_back(8'hC3);
        send_byte(8'hC3, 3);
        sclk_bit(1'b1, 3);
        sclk_bit(1'b0, 3);
        bus.i_mosi = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_sclk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
        model_clear();
        @(negedge clk);
        check("clr_edge_busy",      32'(bus.o_busy),      32'd0);
        check("clr_edge_num_bytes", 32'(bus.o_num_bytes), 32'd0);
        check("clr_edge_overflow",  32'(bus.o_overflow),  32'd0);
        check("clr_edge_frame_err", 32'(bus.o_frame_err), 32'd0);
        repeat (2) @(negedge clk);
        bus.i_sclk = 1'b0;
        bus.i_mosi = 1'b0;
        repeat (TIMEOUT + 20) @(negedge clk);
        check("clr_edge_still_idle", 32'(bus.o_busy), 32'd0);
        tx_q = '{8'h81};
        send_frame(0, 8'h00, 3);
        readback();

        // Randomized frames
        for (int f = 0; f < 12; f++) begin
            int nb;
            int ex;
            if ($urandom_range(0, 3) == 0) idle_clear();
            nb = $urandom_range(0, 17);
            ex = (nb == 0) ? $urandom_range(1, 7) : (($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0);
            tx_q = '{};
            for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom));
            send_frame(ex, 8'($urandom), $urandom_range(2, 6));
            readback();
        end

        check("bytes_outstanding", 32'(exp_byte_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
